// File: rtl/sd_spi_pkg.sv
// Shared constants, error codes and state encoding for the SPI-mode SD block reader.
package sd_spi_pkg;

    localparam logic [5:0] CMD17_IDX   = 6'd17;
    localparam logic [7:0] START_TOKEN = 8'hFE;
    localparam logic [7:0] IDLE_CRC    = 8'hFF;

    localparam logic [1:0] ERR_NONE          = 2'b00;
    localparam logic [1:0] ERR_R1_TIMEOUT    = 2'b01;
    localparam logic [1:0] ERR_R1_BAD        = 2'b10;
    localparam logic [1:0] ERR_TOKEN_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_WAIT_R1,
        ST_READ_R1,
        ST_WAIT_TOKEN,
        ST_READ_DATA,
        ST_READ_CRC,
        ST_FLUSH
    } rd_state_t;

    // 48-bit SPI command frame: start/transmission bits, index, argument, dummy CRC byte
    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, IDLE_CRC};
    endfunction

endpackage

// File: rtl/sd_rx_shifter.sv
// 8-bit MISO shift register with bit counter; o_byte includes the bit being sampled this cycle.
module sd_rx_shifter (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [7:0] o_byte,
    output logic       o_byte_ready
);

    logic [6:0] r_shift;
    logic [2:0] r_cnt;

    // Shift in one bit per enabled clock, MSB first; clear restarts byte alignment
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_en) begin
            r_shift <= {r_shift[5:0], i_bit};
            r_cnt   <= r_cnt + 3'd1;
        end
    end

    assign o_byte       = {r_shift, i_bit};
    assign o_byte_ready = i_en && (r_cnt == 3'd7);

endmodule

// File: rtl/sd_block_reader.sv
// Single-block CMD17 read engine: command out, R1 check, token hunt, byte stream, CRC skip, flush.
module sd_block_reader
    import sd_spi_pkg::*;
#(
    parameter int unsigned ADDR_SHIFT    = 0,
    parameter int unsigned R1_TIMEOUT    = 80,
    parameter int unsigned TOKEN_TIMEOUT = 4096,
    parameter int unsigned BLOCK_BYTES   = 512
) (
    input  logic        d_clock,
    input  logic        reset_n,
    input  logic        card_ready,
    input  logic        start,
    input  logic [31:0] block_addr,
    input  logic        MISO,
    output logic        MOSI,
    output logic        CS,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        busy,
    output logic        done,
    output logic [1:0]  error
);

    localparam int unsigned DATA_BITS = 8 * BLOCK_BYTES;
    localparam int unsigned MAX_A     = (DATA_BITS > 48) ? DATA_BITS : 48;
    localparam int unsigned MAX_B     = (R1_TIMEOUT > TOKEN_TIMEOUT) ? R1_TIMEOUT : TOKEN_TIMEOUT;
    localparam int unsigned CNT_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW        = $clog2(CNT_MAX + 1);

    rd_state_t   r_state;
    rd_state_t   w_state_next;
    logic [CW-1:0] r_cnt;
    logic [47:0] r_cmd;
    logic [6:0]  r_window;
    logic [7:0]  w_window_next;
    logic [1:0]  r_error;
    logic        r_done;
    logic        r_data_valid;
    logic [7:0]  r_data_out;
    logic        w_accept;
    logic        w_err_set;
    logic [1:0]  w_err_code;
    logic        w_rx_en;
    logic [7:0]  w_rx_byte;
    logic        w_rx_ready;
    logic [31:0] w_arg;

    assign w_arg         = block_addr << ADDR_SHIFT;
    assign w_window_next = {r_window, MISO};

    // The start bit of R1 (first 0 in WAIT_R1) is the shifter's first bit; clearing otherwise keeps bytes aligned
    assign w_rx_en = ((r_state == ST_WAIT_R1) && !MISO) || (r_state == ST_READ_R1) ||
                     (r_state == ST_READ_DATA) || (r_state == ST_READ_CRC);

    sd_rx_shifter u_rx (
        .i_clk        (d_clock),
        .i_rst_n      (reset_n),
        .i_clear      (!w_rx_en),
        .i_en         (w_rx_en),
        .i_bit        (MISO),
        .o_byte       (w_rx_byte),
        .o_byte_ready (w_rx_ready)
    );

    // Next-state decode, start acceptance and error classification
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_err_set    = 1'b0;
        w_err_code   = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (start && card_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SEND_CMD;
                end
            end
            ST_SEND_CMD: begin
                if (r_cnt == CW'(47)) w_state_next = ST_WAIT_R1;
            end
            ST_WAIT_R1: begin
                if (!MISO) begin
                    w_state_next = ST_READ_R1;
                end else if (r_cnt == CW'(R1_TIMEOUT - 1)) begin
                    w_err_set    = 1'b1;
                    w_err_code   = ERR_R1_TIMEOUT;
                    w_state_next = ST_FLUSH;
                end
            end
            ST_READ_R1: begin
                if (w_rx_ready) begin
                    if (w_rx_byte == 8'h00) begin
                        w_state_next = ST_WAIT_TOKEN;
                    end else begin
                        w_err_set    = 1'b1;
                        w_err_code   = ERR_R1_BAD;
                        w_state_next = ST_FLUSH;
                    end
                end
            end
            ST_WAIT_TOKEN: begin
                if (w_window_next == START_TOKEN) begin
                    w_state_next = ST_READ_DATA;
                end else if (r_cnt == CW'(TOKEN_TIMEOUT - 1)) begin
                    w_err_set    = 1'b1;
                    w_err_code   = ERR_TOKEN_TIMEOUT;
                    w_state_next = ST_FLUSH;
                end
            end
            ST_READ_DATA: begin
                if (r_cnt == CW'(DATA_BITS - 1)) w_state_next = ST_READ_CRC;
            end
            ST_READ_CRC: begin
                if (r_cnt == CW'(15)) w_state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (r_cnt == CW'(7)) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge d_clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Shared per-state bit/timeout counter: restarts on every state change, saturates otherwise
    always_ff @(posedge d_clock or negedge reset_n) begin
        if (!reset_n)                    r_cnt <= '0;
        else if (w_state_next != r_state) r_cnt <= '0;
        else if (r_cnt != '1)            r_cnt <= r_cnt + CW'(1);
    end

    // Command frame load on accepted start, MSB-first shift during SEND_CMD
    always_ff @(posedge d_clock or negedge reset_n) begin
        if (!reset_n)                    r_cmd <= '1;
        else if (w_accept)               r_cmd <= cmd_frame(CMD17_IDX, w_arg);
        else if (r_state == ST_SEND_CMD) r_cmd <= {r_cmd[46:0], 1'b1};
    end

    // Token search window, empty on entry so R1 bits can never form part of a token
    always_ff @(posedge d_clock or negedge reset_n) begin
        if (!reset_n)                      r_window <= '0;
        else if (r_state == ST_WAIT_TOKEN) r_window <= w_window_next[6:0];
        else                               r_window <= '0;
    end

    // Error code: cleared by an accepted start, set by the failing state
    always_ff @(posedge d_clock or negedge reset_n) begin
        if (!reset_n)       r_error <= ERR_NONE;
        else if (w_accept)  r_error <= ERR_NONE;
        else if (w_err_set) r_error <= w_err_code;
    end

    // Byte output strobe and done pulse on a clean return to IDLE
    always_ff @(posedge d_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_data_valid <= (r_state == ST_READ_DATA) && w_rx_ready;
            if ((r_state == ST_READ_DATA) && w_rx_ready) r_data_out <= w_rx_byte;
            r_done <= (r_state == ST_FLUSH) && (w_state_next == ST_IDLE) && (r_error == ERR_NONE);
        end
    end

    assign MOSI       = (r_state == ST_SEND_CMD) ? r_cmd[47] : 1'b1;
    assign CS         = (r_state == ST_IDLE) || (r_state == ST_FLUSH);
    assign busy       = (r_state != ST_IDLE);
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed bench for sd_block_reader: the initial block plays the card on MISO bit by bit.
`timescale 1ns/1ps
module tb_sd_block_reader;

    logic        d_clock = 1'b0;
    logic        reset_n, card_ready, start, MISO;
    logic [31:0] block_addr;
    logic        MOSI, CS, data_valid, busy, done;
    logic [7:0]  data_out;
    logic [1:0]  error;
    logic        MOSI9, CS9, data_valid9, busy9, done9;
    logic [7:0]  data_out9;
    logic [1:0]  error9;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int vcount, done_cnt, tok_cyc, first_cyc;
    logic [7:0]  got [512];
    logic [47:0] f0, f9;

    always #5 d_clock = ~d_clock;

    sd_block_reader #(.ADDR_SHIFT(0), .R1_TIMEOUT(80), .TOKEN_TIMEOUT(4096), .BLOCK_BYTES(512)) dut (
        .d_clock(d_clock), .reset_n(reset_n), .card_ready(card_ready), .start(start),
        .block_addr(block_addr), .MISO(MISO), .MOSI(MOSI), .CS(CS), .data_out(data_out),
        .data_valid(data_valid), .busy(busy), .done(done), .error(error)
    );

    sd_block_reader #(.ADDR_SHIFT(9), .R1_TIMEOUT(80), .TOKEN_TIMEOUT(4096), .BLOCK_BYTES(512)) dut9 (
        .d_clock(d_clock), .reset_n(reset_n), .card_ready(card_ready), .start(start),
        .block_addr(block_addr), .MISO(MISO), .MOSI(MOSI9), .CS(CS9), .data_out(data_out9),
        .data_valid(data_valid9), .busy(busy9), .done(done9), .error(error9)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge d_clock);
        #1;
        cyc++;
        if (data_valid === 1'b1) begin
            if (vcount < 512) got[vcount] = data_out;
            if (vcount == 0) first_cyc = cyc;
            vcount++;
        end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic clr();
        vcount   = 0;
        done_cnt = 0;
        for (int i = 0; i < 512; i++) got[i] = 'x;
    endtask

    task automatic send_bit(input logic b);
        MISO = b;
        step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic issue(input logic [31:0] a);
        clr();
        MISO       = 1'b1;
        card_ready = 1'b1;
        block_addr = a;
        start      = 1'b1;
        step();
        start = 1'b0;
        chk("cs_cmd", 64'(CS), 64'd0);
        for (int i = 47; i >= 0; i--) begin
            f0[i] = MOSI;
            f9[i] = MOSI9;
            step();
        end
    endtask

    task automatic read_prefix(input logic [31:0] a);
        issue(a);
        send_ones(3);
        send_byte(8'h00);
        send_ones(20);
        send_byte(8'hFE);
        tok_cyc = cyc;
    endtask

    task automatic send_data(input int first, input int n);
        for (int k = first; k < first + n; k++) send_byte(8'(k));
    endtask

    task automatic check_block();
        int bad;
        bad = 0;
        for (int i = 0; i < 512; i++) if (got[i] !== 8'(i)) bad++;
        chk("nvalid", 64'(vcount), 64'd512);
        chk("bad_bytes", 64'(bad), 64'd0);
    endtask

    task automatic finish_read();
        send_byte(8'hAA);
        send_byte(8'h55);
        chk("cs_flush", 64'(CS), 64'd1);
        chk("busy_flush", 64'(busy), 64'd1);
        send_ones(7);
        chk("done_early", 64'(done), 64'd0);
        send_bit(1'b1);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("err_ok", 64'(error), 64'd0);
        step();
        chk("done_once", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; card_ready = 1'b0; start = 1'b0; MISO = 1'b1; block_addr = '0;
        clr();
        step(); step(); step();
        chk("rst_mosi", 64'(MOSI), 64'd1);
        chk("rst_cs", 64'(CS), 64'd1);
        chk("rst_dout", 64'(data_out), 64'd0);
        chk("rst_dvalid", 64'(data_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        reset_n = 1'b1;
        step();

        // full read, SDHC addressing
        read_prefix(32'h0000_0010);
        chk("frame_a0", 64'(f0), 64'h51_00000010_FF);
        chk("frame_a9", 64'(f9), 64'h51_00002000_FF);
        send_data(0, 512);
        chk("first_valid_lat", 64'(first_cyc - tok_cyc), 64'd8);
        check_block();
        finish_read();
        chk("dut9_idle", 64'({data_out9, CS9, data_valid9, busy9, done9, error9}), 64'({8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}));

        // card never answers
        issue(32'h0);
        send_ones(79);
        chk("r1to_pre", 64'(error), 64'd0);
        send_bit(1'b1);
        chk("r1to_err", 64'(error), 64'd1);
        chk("r1to_cs", 64'(CS), 64'd1);
        send_ones(7);
        chk("r1to_busy_flush", 64'(busy), 64'd1);
        step();
        chk("r1to_busy_end", 64'(busy), 64'd0);
        chk("r1to_nodone", 64'(done_cnt), 64'd0);

        // R1 reports an error; byte addressing frame check
        issue(32'h0000_0003);
        chk("frame_b0", 64'(f0), 64'h51_00000003_FF);
        chk("frame_b9", 64'(f9), 64'h51_00000600_FF);
        send_ones(2);
        send_byte(8'h05);
        chk("r1bad_err", 64'(error), 64'd2);
        chk("r1bad_cs", 64'(CS), 64'd1);
        send_ones(8);
        chk("r1bad_busy", 64'(busy), 64'd0);
        chk("r1bad_nvalid", 64'(vcount), 64'd0);
        chk("r1bad_nodone", 64'(done_cnt), 64'd0);

        // token never arrives
        issue(32'h0);
        chk("err_cleared", 64'(error), 64'd0);
        send_ones(3);
        send_byte(8'h00);
        send_ones(4095);
        chk("tokto_pre", 64'(error), 64'd0);
        send_bit(1'b1);
        chk("tokto_err", 64'(error), 64'd3);
        chk("tokto_cs", 64'(CS), 64'd1);
        send_ones(8);
        chk("tokto_busy", 64'(busy), 64'd0);
        chk("tokto_nodone", 64'(done_cnt), 64'd0);

        // start without card_ready is ignored and the old error is held
        card_ready = 1'b0;
        block_addr = 32'h5;
        start = 1'b1;
        step(); step();
        start = 1'b0;
        step();
        chk("nrdy_busy", 64'(busy), 64'd0);
        chk("nrdy_cs", 64'(CS), 64'd1);
        chk("nrdy_mosi", 64'(MOSI), 64'd1);
        chk("nrdy_err_held", 64'(error), 64'd3);

        // reset in the middle of the data phase
        read_prefix(32'h40);
        send_data(0, 100);
        chk("mid_nvalid", 64'(vcount), 64'd100);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_dvalid", 64'(data_valid), 64'd0);
        chk("mid_rst_cs", 64'(CS), 64'd1);
        chk("mid_rst_mosi", 64'(MOSI), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("mid_rst_nodone", 64'(done_cnt), 64'd0);

        // new read; start while busy and card_ready drop are both ignored
        read_prefix(32'h41);
        send_data(0, 10);
        begin
            logic [7:0] b;
            b = 8'h0A;
            start      = 1'b1;
            block_addr = 32'hDEAD_BEEF;
            card_ready = 1'b0;
            send_bit(b[7]);
            start = 1'b0;
            chk("busy_start_mosi", 64'(MOSI), 64'd1);
            chk("busy_start_cs", 64'(CS), 64'd0);
            for (int i = 6; i >= 0; i--) send_bit(b[i]);
        end
        send_data(11, 501);
        check_block();
        finish_read();
        card_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
